freq_divider_prog: RTL

//  Runtime-programmable clock divider: successor to the fixed-ratio divider.

---
 rtl/freq_divider_prog.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/freq_divider_prog.sv
// -----------------------------------------------------------------------------
// freq_divider_prog
//
// Runtime-programmable 50%-duty clock divider with start/stop control, a
// configurable idle level, glitch-free divisor reload at full-period
// boundaries, and single-cycle edge strobes for logic in the Clk_in domain.
//
// Parameters
//   CNT_W       width of the half-period counter and divisor registers
//   DIV_RESET   half-period (in Clk_in cycles) loaded by reset; must be >= 1
//   IDLE_LEVEL  Clk_out level while stopped (CPOL)
//
// Ports
//   Clk_in     in   1      system clock, all logic on posedge
//   Rst_n      in   1      asynchronous active-low reset (release is synchronised)
//   En         in   1      run request, level-sensitive
//   Half_div   in   CNT_W  new half-period value in Clk_in cycles
//   Div_load   in   1      strobe: capture Half_div as the pending divisor
//   Div_busy   out  1      a pending divisor has not yet been applied
//   Clk_out    out  1      divided clock (registered)
//   Rise_stb   out  1      1 in the cycle Clk_out has just become 1
//   Fall_stb   out  1      1 in the cycle Clk_out has just become 0
//   Running    out  1      state is not IDLE
//   State_dbg  out  2      current FSM state (IDLE=0, RUN=1, STOPPING=2)
//
// Handshake: Div_load is a one-cycle strobe with no back-pressure. Every
// strobe is accepted; a strobe while Div_busy=1 overwrites the pending value
// (last write wins). Div_busy falls on the edge that copies the pending value
// into the active half-period.
// -----------------------------------------------------------------------------
module freq_divider_prog #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DIV_RESET  = 5,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             Clk_in,
  input  logic             Rst_n,
  input  logic             En,
  input  logic [CNT_W-1:0] Half_div,
  input  logic             Div_load,
  output logic             Div_busy,
  output logic             Clk_out,
  output logic             Rise_stb,
  output logic             Fall_stb,
  output logic             Running,
  output logic [1:0]       State_dbg
);

  // A zero reset half-period would make the counter compare against all-ones
  // and break the period arithmetic, so refuse to elaborate.
  if (DIV_RESET == 0) begin : g_bad_div_reset
    $error("freq_divider_prog: DIV_RESET must be at least 1");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  localparam logic [CNT_W-1:0] HP_RESET = CNT_W'(DIV_RESET);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic             IDLE_LVL = IDLE_LEVEL;

  // ---------------------------------------------------------------------------
  // Reset synchroniser: assertion reaches every flop immediately, release is
  // aligned to Clk_in so no flop sees a release near its active edge.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_int_n;

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge Clk_in or negedge Rst_n) begin
    if (!Rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] hp_q,    hp_d;
  logic [CNT_W-1:0] pend_q,  pend_d;
  logic             busy_q,  busy_d;
  logic             clk_q,   clk_d;
  logic             rise_q,  rise_d;
  logic             fall_q,  fall_d;

  logic [CNT_W-1:0] hp_m1;
  logic             toggle;
  logic             to_idle;
  logic             apply;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hp_d    = hp_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    clk_d   = clk_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    // HP is never 0, so HP-1 cannot wrap.
    hp_m1   = hp_q - ONE;
    toggle  = (state_q != ST_IDLE) && (cnt_q == hp_m1);
    // The toggle that brings Clk_out back to the idle level closes a full
    // period; it is the only point where stopping or a reload may take effect.
    to_idle = toggle && (clk_q != IDLE_LVL);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        clk_d = IDLE_LVL;
        if (En) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN, ST_STOP: begin
        if (toggle) begin
          cnt_d  = '0;
          clk_d  = ~clk_q;
          rise_d = ~clk_q;
          fall_d = clk_q;
        end else begin
          cnt_d = cnt_q + ONE;
        end

        if (state_q == ST_RUN) begin
          // Dropping En on the closing toggle stops at once; otherwise the
          // current period is finished in STOPPING.
          if (!En) begin
            state_d = to_idle ? ST_IDLE : ST_STOP;
          end
        end else begin
          // En is deliberately ignored here so a started period always completes.
          if (to_idle) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        clk_d   = IDLE_LVL;
      end
    endcase

    // Apply the pending divisor using the value held before this edge; a load
    // on the same edge is captured afterwards and keeps busy set.
    apply = busy_q && ((state_q == ST_IDLE) || to_idle);
    if (apply) begin
      hp_d   = pend_q;
      busy_d = 1'b0;
    end

    if (Div_load) begin
      pend_d = (Half_div == '0) ? ONE : Half_div;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge Clk_in or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hp_q    <= HP_RESET;
      pend_q  <= HP_RESET;
      busy_q  <= 1'b0;
      clk_q   <= IDLE_LVL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign Div_busy  = busy_q;
  assign Clk_out   = clk_q;
  assign Rise_stb  = rise_q;
  assign Fall_stb  = fall_q;
  assign Running   = (state_q != ST_IDLE);
  assign State_dbg = state_q;

endmodule
